router_a_buf: RTL and testbench
===============================

# router_a_buf

Buffered, parametrised successor to the Kalman datapath's combinational input router. Selects write data (DATA_IN, ALU result, or constants) and write address (ctl_a or DIR), qualifies the write per sel_write, and queues qualified writes in a DEPTH-entry FIFO. The FIFO drains to the register file under a valid/ready handshake, so external loads and ALU results are never lost while the write port is busy. The read address dirb is registered alongside.

## Interface
- W, 24, data width
- ADDRW, 5, register-file address width
- DEPTH, 4, write FIFO entries; power of two, ≥2
- CW, $clog2(DEPTH+1), occupancy counter width
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- DATA_IN  in  W  external input data
- result  in  W  ALU result
- ctl_a, ctl_b  in  ADDRW  controller write / read addresses
- DIR  in  ADDRW  external address
- WRITE  in  1  write request
- READY  in  1  ALU result valid
- sel_data  in  2  0=DATA_IN, 1=result, 2=all-zeros, 3=all-ones
- sel_dira  in  1  0=ctl_a, 1=DIR (write address)
- sel_dirb  in  1  0=ctl_b, 1=DIR (read address)
- sel_write  in  2  0=WRITE, 1=WRITE&READY, 2=never, 3=always
- flush  in  1  discard all queued writes
- rf_ready  in  1  register file accepts a write this cycle
- data  out  W  FIFO head data
- dira  out  ADDRW  FIFO head address
- write  out  1  head valid (FIFO non-empty)
- dirb  out  ADDRW  registered read address
- count  out  CW  FIFO occupancy
- full  out  1  count==DEPTH
- overflow  out  1  sticky: qualified write dropped

## Operation
- Qualification: req = per sel_write from the current-cycle WRITE/READY. Entry = {mux(sel_data), mux(sel_dira)} from the same cycle.
- push = req & ~flush & (~full | pop); pop = write & rf_ready & ~flush.
- Push writes the entry at wr_ptr and increments it. Pop increments rd_ptr. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: req while full and no pop → entry dropped, overflow←1, count unchanged. Full with simultaneous pop → push accepted, count stays DEPTH.
- Empty: pop is impossible because write=0. There is no bypass path: a request in an empty cycle appears on the outputs the next cycle.
- flush: pointers and count ←0, overflow ←0, and any push or pop in that cycle is suppressed. dirb still updates.
- data/dira are driven from the head entry. When empty they hold the last popped or stale value, and consumers ignore them.
- dirb ← mux(sel_dirb) every cycle.
- Order: writes reach the register file in request order; no reordering and no combining of same-address writes.

## Timing
- Reset (rst_n=0 at edge): count=0, write=0, full=0, overflow=0, dirb=0, pointers=0. data/dira read storage, which is reset to 0, so both are 0.
- Request-to-write latency is 1 cycle minimum: a request at edge t gives write=1 and data/dira valid from t+1. Add one cycle of delay for every cycle the entries ahead of it occupy the head.
- A handshake completes at an edge with write & rf_ready. The head holds stable while rf_ready=0.
- Throughput: 1 push and 1 pop per cycle, so sustained back-to-back writes with rf_ready=1 never fill the FIFO.
- dirb latency is 1 cycle.
- Reset mid-operation discards queued writes, including any handshake in the same cycle, because reset has priority over flush, push and pop.
- overflow is set at the edge of the dropped request and is visible from the next cycle.

## Test plan
- Exhaustive mux/qualify: after reset, loop over all sel_data × sel_dira × sel_write × WRITE × READY with rf_ready=1. DATA_IN=123456, result=C0FFEE, ctl_a=03, DIR=12 → write=1 exactly one cycle after each qualifying combo, with data ∈ {123456, C0FFEE, 000000, FFFFFF} and dira ∈ {03, 12} as selected. sel_write=2 never writes; sel_write=1 writes only when WRITE=READY=1.
- Backpressure/fill: rf_ready=0, 5 consecutive requests with data 1..5 → count 1,2,3,4,4, full=1 after the 4th, overflow=1 after the 5th. Then rf_ready=1 → data 1,2,3,4 on successive cycles, then write=0 and count=0.
- Full with simultaneous push and pop: FIFO full, rf_ready=1, request data=AA → count stays 4, overflow stays 0, AA emerges 4 cycles later.
- Pointer wrap: 10 requests interleaved with irregular rf_ready (pattern 1,0,1,1,0…) → output sequence matches input order exactly, with no duplicates or losses.
- Flush: 3 entries queued, flush=1 together with a request and rf_ready=1 → next cycle count=0, write=0, overflow=0, and the request is not queued.
- Reset mid-burst: 2 entries queued, rst_n=0 for one edge → all outputs at reset values. A subsequent request with data=55 appears alone after 1 cycle.
- dirb: sel_dirb toggled 0/1 each cycle with ctl_b=1C, DIR=12 → dirb is 1C/12, delayed one cycle.

Source files
------------

// File: rtl/router_a_buf.sv
`default_nettype none
// ============================================================================
// Module   : router_a_buf
// Brief    : Write-data/address router with a DEPTH-entry write FIFO drained
//            to the register file over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module router_a_buf #(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     DATA_IN,
    input  logic [W-1:0]     result,
    input  logic [ADDRW-1:0] ctl_a,
    input  logic [ADDRW-1:0] ctl_b,
    input  logic [ADDRW-1:0] DIR,
    input  logic             WRITE,
    input  logic             READY,
    input  logic [1:0]       sel_data,
    input  logic             sel_dira,
    input  logic             sel_dirb,
    input  logic [1:0]       sel_write,
    input  logic             flush,
    input  logic             rf_ready,
    output logic [W-1:0]     data,
    output logic [ADDRW-1:0] dira,
    output logic             write,
    output logic [ADDRW-1:0] dirb,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [W-1:0]       r_mem_data [DEPTH];
    logic [ADDRW-1:0]   r_mem_addr [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic [ADDRW-1:0]   r_dirb;

    logic [W-1:0]       w_entry_data;
    logic [ADDRW-1:0]   w_entry_addr;
    logic               w_req;
    logic               w_full;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    always_comb begin
        w_entry_data = DATA_IN;
        case (sel_data)
            2'd0:    w_entry_data = DATA_IN;
            2'd1:    w_entry_data = result;
            2'd2:    w_entry_data = '0;
            default: w_entry_data = '1;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        case (sel_write)
            2'd0:    w_req = WRITE;
            2'd1:    w_req = WRITE & READY;
            2'd2:    w_req = 1'b0;
            default: w_req = 1'b1;
        endcase
    end

    assign w_entry_addr = sel_dira ? DIR : ctl_a;
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & rf_ready & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push       = w_req & ~flush & (~w_full | w_pop);
    assign w_drop       = w_req & ~flush & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dirb     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_addr[i] <= '0;
            end
        end else begin
            r_dirb <= sel_dirb ? DIR : ctl_b;
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem_data[r_wr_ptr] <= w_entry_data;
                    r_mem_addr[r_wr_ptr] <= w_entry_addr;
                    r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign data     = r_mem_data[r_rd_ptr];
    assign dira     = r_mem_addr[r_rd_ptr];
    assign write    = w_valid;
    assign dirb     = r_dirb;
    assign count    = r_count;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_router_a_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_a_buf
// Brief    : Directed self-checking bench for router_a_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_a_buf;

    localparam int W     = 24;
    localparam int ADDRW = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     DATA_IN;
    logic [W-1:0]     result;
    logic [ADDRW-1:0] ctl_a;
    logic [ADDRW-1:0] ctl_b;
    logic [ADDRW-1:0] DIR;
    logic             WRITE;
    logic             READY;
    logic [1:0]       sel_data;
    logic             sel_dira;
    logic             sel_dirb;
    logic [1:0]       sel_write;
    logic             flush;
    logic             rf_ready;
    logic [W-1:0]     data;
    logic [ADDRW-1:0] dira;
    logic             write;
    logic [ADDRW-1:0] dirb;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    router_a_buf #(.W(W), .ADDRW(ADDRW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .DATA_IN(DATA_IN), .result(result),
        .ctl_a(ctl_a), .ctl_b(ctl_b), .DIR(DIR), .WRITE(WRITE), .READY(READY),
        .sel_data(sel_data), .sel_dira(sel_dira), .sel_dirb(sel_dirb),
        .sel_write(sel_write), .flush(flush), .rf_ready(rf_ready),
        .data(data), .dira(dira), .write(write), .dirb(dirb),
        .count(count), .full(full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_write"}, 32'(write), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_dirb"}, 32'(dirb), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_dira"}, 32'(dira), 32'd0);
    endtask

    logic [W-1:0] exp_d;
    logic         exp_q;
    int           got;
    int           bound;
    logic [W-1:0] seq [4];
    logic         rf_pat [10];

    initial begin
        rst_n = 1'b0; DATA_IN = 24'h123456; result = 24'hC0FFEE;
        ctl_a = 5'h03; ctl_b = 5'h1C; DIR = 5'h12;
        WRITE = 1'b0; READY = 1'b0; sel_data = 2'd0; sel_dira = 1'b0;
        sel_dirb = 1'b0; sel_write = 2'd2; flush = 1'b0; rf_ready = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Exhaustive mux/qualify sweep with the consumer always ready.
        rf_ready = 1'b1;
        for (int sd = 0; sd < 4; sd++)
            for (int sa = 0; sa < 2; sa++)
                for (int sw = 0; sw < 4; sw++)
                    for (int wr = 0; wr < 2; wr++)
                        for (int rd = 0; rd < 2; rd++) begin
                            sel_data = 2'(sd); sel_dira = 1'(sa); sel_write = 2'(sw);
                            WRITE = 1'(wr); READY = 1'(rd);
                            case (sw)
                                0:       exp_q = 1'(wr);
                                1:       exp_q = 1'(wr & rd);
                                2:       exp_q = 1'b0;
                                default: exp_q = 1'b1;
                            endcase
                            case (sd)
                                0:       exp_d = 24'h123456;
                                1:       exp_d = 24'hC0FFEE;
                                2:       exp_d = 24'h000000;
                                default: exp_d = 24'hFFFFFF;
                            endcase
                            step();
                            check("mux_write", 32'(write), 32'(exp_q));
                            if (exp_q) begin
                                check("mux_data", 32'(data), 32'(exp_d));
                                check("mux_dira", 32'(dira), (sa != 0) ? 32'h12 : 32'h03);
                            end
                        end
        sel_write = 2'd2; WRITE = 1'b0; READY = 1'b0;
        sel_data = 2'd0; sel_dira = 1'b0;
        step();
        check("mux_drain", 32'(write), 32'd0);

        // Backpressure and fill: fifth request is dropped.
        rf_ready = 1'b0; sel_write = 2'd3;
        for (int i = 1; i <= 5; i++) begin
            DATA_IN = 24'(i);
            step();
            check("fill_count", 32'(count), (i >= 4) ? 32'd4 : 32'(i));
            check("fill_full", 32'(full), (i >= 4) ? 32'd1 : 32'd0);
            check("fill_ovf", 32'(overflow), (i >= 5) ? 32'd1 : 32'd0);
        end
        sel_write = 2'd2; rf_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check("drain_write", 32'(write), 32'd1);
            check("drain_data", 32'(data), 32'(j));
            step();
        end
        check("drain_empty", 32'(write), 32'd0);
        check("drain_count", 32'(count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_clr_ovf", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop.
        rf_ready = 1'b0; sel_write = 2'd3;
        for (int i = 0; i < 4; i++) begin
            DATA_IN = 24'h10 + 24'(i);
            step();
        end
        check("pp_full", 32'(full), 32'd1);
        rf_ready = 1'b1; DATA_IN = 24'hAA;
        step();
        check("pp_count", 32'(count), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        sel_write = 2'd2;
        seq[0] = 24'h11; seq[1] = 24'h12; seq[2] = 24'h13; seq[3] = 24'hAA;
        for (int j = 0; j < 4; j++) begin
            check("pp_seq", 32'(data), 32'(seq[j]));
            step();
        end
        check("pp_empty", 32'(write), 32'd0);

        // Pointer wrap under irregular consumer readiness.
        rf_pat[0] = 1; rf_pat[1] = 0; rf_pat[2] = 1; rf_pat[3] = 1; rf_pat[4] = 0;
        rf_pat[5] = 1; rf_pat[6] = 1; rf_pat[7] = 0; rf_pat[8] = 1; rf_pat[9] = 1;
        got = 0;
        bound = 0;
        while ((got < 10) && (bound < 60)) begin
            if (bound < 10) begin
                sel_write = 2'd3; DATA_IN = 24'h100 + 24'(bound);
            end else begin
                sel_write = 2'd2;
            end
            rf_ready = rf_pat[bound % 10];
            if (write && rf_ready) begin
                check("wrap_seq", 32'(data), 32'h100 + 32'(got));
                got++;
            end
            step();
            bound++;
        end
        check("wrap_total", 32'(got), 32'd10);
        check("wrap_ovf", 32'(overflow), 32'd0);
        check("wrap_empty", 32'(count), 32'd0);

        // Flush with a concurrent request and handshake.
        sel_write = 2'd3; rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DATA_IN = 24'h200 + 24'(i);
            step();
        end
        check("fl_pre_count", 32'(count), 32'd3);
        flush = 1'b1; rf_ready = 1'b1; DATA_IN = 24'h2FF;
        step();
        check("fl_count", 32'(count), 32'd0);
        check("fl_write", 32'(write), 32'd0);
        check("fl_ovf", 32'(overflow), 32'd0);
        flush = 1'b0; sel_write = 2'd2;
        step();
        check("fl_noqueue", 32'(write), 32'd0);

        // Reset in the middle of a burst.
        sel_write = 2'd3; rf_ready = 1'b0; sel_dirb = 1'b1;
        for (int i = 0; i < 2; i++) begin
            DATA_IN = 24'h300 + 24'(i);
            step();
        end
        rst_n = 1'b0; rf_ready = 1'b1;
        step();
        check_reset_state("midrst");
        rst_n = 1'b1; rf_ready = 1'b0; DATA_IN = 24'h55; sel_dirb = 1'b0;
        step();
        sel_write = 2'd2;
        check("rst_after_write", 32'(write), 32'd1);
        check("rst_after_data", 32'(data), 32'h55);
        check("rst_after_count", 32'(count), 32'd1);
        rf_ready = 1'b1;
        step();
        check("rst_after_alone", 32'(write), 32'd0);

        // Read address register.
        ctl_b = 5'h1C; DIR = 5'h12;
        for (int i = 0; i < 6; i++) begin
            sel_dirb = 1'(i % 2);
            step();
            check("dirb", 32'(dirb), (i % 2 != 0) ? 32'h12 : 32'h1C);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
